// File: rtl/rmii_frame_tx.sv
// RMII transmit framer: preamble/SFD, dibit payload, zero pad, CRC-32 FCS, inter-packet gap.
// Output is dibit-serial, LSB-first within each byte, registered for direct TXEN/TXD drive.
module rmii_frame_tx #(
    parameter int unsigned PREAMBLE_DIBITS    = 32,
    parameter int unsigned MIN_PAYLOAD_DIBITS = 240,
    parameter int unsigned IPG_DIBITS         = 48
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       trigger_in,
    input  logic [1:0] data_in,
    input  logic       last_dibit_in,
    output logic       ready_out,
    output logic       data_ready_out,
    output logic       axiov,
    output logic [1:0] axiod
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_PAD,
        S_FCS,
        S_IPG
    } state_t;

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_DIBITS - 1);
    localparam logic [15:0] IPG_LAST = 16'(IPG_DIBITS - 1);
    localparam logic [16:0] MIN_LEN  = 17'(MIN_PAYLOAD_DIBITS);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [15:0] paylen_q;
    logic [15:0] paylen_d;
    logic [16:0] paylen_inc;
    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [1:0]  crc_din;
    logic [1:0]  fcs_dibit;
    logic        ready_q;
    logic        axiov_q;
    logic [1:0]  axiod_q;

    assign paylen_inc = {1'b0, paylen_q} + 17'd1;
    assign paylen_d   = (paylen_q == 16'hFFFF) ? paylen_q : paylen_inc[15:0];
    assign crc_din    = (state_q == S_DATA) ? data_in : 2'b00;
    assign fcs_dibit  = ~crc_q[{cnt_q[3:0], 1'b0} +: 2];

    // Reflected CRC-32 advanced by one dibit, bit0 first
    always_comb begin
        crc_d = crc_q;
        for (int unsigned i = 0; i < 2; i++) begin
            if (crc_d[0] ^ crc_din[i]) begin
                crc_d = {1'b0, crc_d[31:1]} ^ CRC_POLY;
            end else begin
                crc_d = {1'b0, crc_d[31:1]};
            end
        end
    end

    // Frame sequencer with registered TXEN/TXD and ready
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            paylen_q <= '0;
            crc_q    <= '1;
            ready_q  <= 1'b0;
            axiov_q  <= 1'b0;
            axiod_q  <= 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    axiov_q <= 1'b0;
                    axiod_q <= 2'b00;
                    if (ready_q && trigger_in) begin
                        ready_q <= 1'b0;
                        cnt_q   <= '0;
                        crc_q   <= '1;
                        state_q <= S_PREAMBLE;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_PREAMBLE: begin
                    axiov_q <= 1'b1;
                    if (cnt_q == PRE_LAST) begin
                        axiod_q  <= 2'b11;
                        cnt_q    <= '0;
                        paylen_q <= '0;
                        state_q  <= S_DATA;
                    end else begin
                        axiod_q <= 2'b01;
                        cnt_q   <= cnt_q + 16'd1;
                    end
                end
                S_DATA: begin
                    axiov_q  <= 1'b1;
                    axiod_q  <= data_in;
                    crc_q    <= crc_d;
                    paylen_q <= paylen_d;
                    if (last_dibit_in) begin
                        cnt_q <= '0;
                        if (paylen_inc < MIN_LEN) begin
                            state_q <= S_PAD;
                        end else begin
                            state_q <= S_FCS;
                        end
                    end
                end
                S_PAD: begin
                    axiov_q  <= 1'b1;
                    axiod_q  <= 2'b00;
                    crc_q    <= crc_d;
                    paylen_q <= paylen_d;
                    if (paylen_inc == MIN_LEN) begin
                        cnt_q   <= '0;
                        state_q <= S_FCS;
                    end
                end
                S_FCS: begin
                    axiov_q <= 1'b1;
                    axiod_q <= fcs_dibit;
                    if (cnt_q == 16'd15) begin
                        cnt_q   <= '0;
                        state_q <= S_IPG;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_IPG: begin
                    axiov_q <= 1'b0;
                    axiod_q <= 2'b00;
                    if (cnt_q == IPG_LAST) begin
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_out      = ready_q;
    assign data_ready_out = (state_q == S_DATA);
    assign axiov          = axiov_q;
    assign axiod          = axiod_q;

endmodule

// File: tb/tb_rmii_frame_tx.sv
// Bench for rmii_frame_tx: two instances (default padding and padding disabled) share stimulus;
// captured frames are compared with a reference frame built from payload, pad rule and a bitwise CRC-32.
module tb_rmii_frame_tx;

    typedef logic [1:0] dq_t[$];

    typedef struct {
        string name;
        int    kind;   // 0 ascii "123456789", 1 all ones, 2 row frame, 3 zeros, 4 random
        int    n;
        int    len_a;  // expected axiov-high cycles, MIN_PAYLOAD_DIBITS=240
        int    len_b;  // expected axiov-high cycles, MIN_PAYLOAD_DIBITS=0
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trig = 1'b0;
    logic [1:0] din = 2'b00;
    logic       last = 1'b0;
    logic       rdy_a, drdy_a, v_a, rdy_b, drdy_b, v_b;
    logic [1:0] d_a, d_b;

    int checks = 0;
    int failures = 0;

    dq_t cap_a, cap_b;
    int  gaps_a[$];
    int  gaps_b[$];
    int  zrun_a = 0;
    int  zrun_b = 0;

    always #5 clk = ~clk;

    rmii_frame_tx dut_a (
        .clk_in(clk), .rst_in(rst), .trigger_in(trig), .data_in(din), .last_dibit_in(last),
        .ready_out(rdy_a), .data_ready_out(drdy_a), .axiov(v_a), .axiod(d_a)
    );

    rmii_frame_tx #(.MIN_PAYLOAD_DIBITS(0)) dut_b (
        .clk_in(clk), .rst_in(rst), .trigger_in(trig), .data_in(din), .last_dibit_in(last),
        .ready_out(rdy_b), .data_ready_out(drdy_b), .axiov(v_b), .axiod(d_b)
    );

    // capture line activity away from the active edge
    always @(negedge clk) begin
        if (v_a) begin
            cap_a.push_back(d_a);
            if (zrun_a > 0) gaps_a.push_back(zrun_a);
            zrun_a = 0;
        end else zrun_a++;
        if (v_b) begin
            cap_b.push_back(d_b);
            if (zrun_b > 0) gaps_b.push_back(zrun_b);
            zrun_b = 0;
        end else zrun_b++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc32(input dq_t body);
        logic [31:0] c = 32'hFFFFFFFF;
        logic [1:0]  d;
        foreach (body[k]) begin
            d = body[k];
            for (int b = 0; b < 2; b++) begin
                c = (c[0] ^ d[b]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return c;
    endfunction

    function automatic dq_t build_frame(input dq_t pl, input int min_len);
        dq_t f;
        dq_t body;
        logic [31:0] fcs;
        for (int k = 0; k < 31; k++) f.push_back(2'b01);
        f.push_back(2'b11);
        body = pl;
        while (body.size() < min_len) body.push_back(2'b00);
        fcs = ~crc32(body);
        foreach (body[k]) f.push_back(body[k]);
        for (int k = 0; k < 16; k++) f.push_back(fcs[2*k +: 2]);
        return f;
    endfunction

    function automatic void push_byte(inout dq_t q, input logic [7:0] b);
        for (int k = 0; k < 4; k++) q.push_back(b[2*k +: 2]);
    endfunction

    function automatic dq_t make_pl(input int kind, input int n);
        dq_t q;
        string s = "123456789";
        logic [15:0] row = 16'd5;
        case (kind)
            0: for (int i = 0; i < 9; i++) push_byte(q, s[i]);
            1: for (int i = 0; i < n; i++) q.push_back(2'b11);
            2: begin
                for (int k = 0; k < 8; k++) q.push_back(row[2*k +: 2]);
                for (int j = 0; j < 160; j++) push_byte(q, 8'(j));
            end
            3: for (int i = 0; i < n; i++) q.push_back(2'b00);
            default: for (int i = 0; i < n; i++) q.push_back(2'($urandom_range(0, 3)));
        endcase
        return q;
    endfunction

    function automatic logic [31:0] fcs_of(input dq_t f);
        logic [31:0] v = '0;
        if (f.size() >= 16)
            for (int k = 0; k < 16; k++) v[2*k +: 2] = f[f.size() - 16 + k];
        return v;
    endfunction

    task automatic cmp_frame(input string name, input dq_t act, input dq_t exp);
        int bad = -1;
        checks++;
        for (int k = 0; k < exp.size() && k < act.size(); k++)
            if (bad < 0 && act[k] !== exp[k]) bad = k;
        if (bad < 0 && act.size() != exp.size()) bad = (act.size() < exp.size()) ? act.size() : exp.size();
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s: first difference at dibit %0d, got len %0d expected len %0d", name, bad,
                     act.size(), exp.size());
        end
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (!(rdy_a && rdy_b && !v_a && !v_b) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) chk({name, "_idle_timeout"}, 32'(t), 32'd0);
    endtask

    task automatic drive(input dq_t pl, input bit drop_trig, input int stop_at);
        int t = 0;
        while (!drdy_a && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 400) begin
            chk("data_ready_timeout", 32'(t), 32'd0);
            return;
        end
        if (drop_trig) trig = 1'b0;
        for (int i = 0; i < stop_at; i++) begin
            din  = pl[i];
            last = (i == pl.size() - 1);
            @(posedge clk); #1;
        end
        last = 1'b0;
        din  = 2'b00;
    endtask

    task automatic send(input string name, input dq_t pl);
        wait_idle(name);
        cap_a.delete();
        cap_b.delete();
        @(negedge clk);
        trig = 1'b1;
        @(posedge clk); #1;
        trig = 1'b0;
        drive(pl, 1'b0, pl.size());
        wait_idle(name);
    endtask

    vec_t vecs[$];

    initial begin
        dq_t pl;
        int n;
        vecs.push_back('{"ascii", 0, 36, 288, 84});
        vecs.push_back('{"ones100", 1, 100, 288, 148});
        vecs.push_back('{"row", 2, 648, 696, 696});
        vecs.push_back('{"one_dibit", 3, 1, 288, 49});
        vecs.push_back('{"rand239", 4, 239, 288, 287});
        vecs.push_back('{"rand240", 4, 240, 288, 288});
        vecs.push_back('{"rand241", 4, 241, 289, 289});

        // reset state while held in reset
        #1;
        chk("rst_axiov", 32'(v_a), 32'd0);
        chk("rst_axiod", 32'(d_a), 32'd0);
        chk("rst_ready", 32'(rdy_a), 32'd0);
        chk("rst_data_ready", 32'(drdy_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("ready_before_edge", 32'(rdy_a), 32'd0);
        @(posedge clk); #1;
        chk("ready_after_release", 32'(rdy_a), 32'd1);

        // table-driven frames
        foreach (vecs[i]) begin
            pl = make_pl(vecs[i].kind, vecs[i].n);
            send(vecs[i].name, pl);
            chk({vecs[i].name, "_len_a"}, 32'(cap_a.size()), 32'(vecs[i].len_a));
            chk({vecs[i].name, "_len_b"}, 32'(cap_b.size()), 32'(vecs[i].len_b));
            cmp_frame({vecs[i].name, "_frame_a"}, cap_a, build_frame(pl, 240));
            cmp_frame({vecs[i].name, "_frame_b"}, cap_b, build_frame(pl, 0));
            if (vecs[i].kind == 0) chk("ascii_fcs", fcs_of(cap_b), 32'hCBF43926);
        end

        // randomized frames against the reference model
        for (int r = 0; r < 8; r++) begin
            n  = $urandom_range(1, 400);
            pl = make_pl(4, n);
            send("random", pl);
            chk("random_len_a", 32'(cap_a.size()), 32'(32 + ((n > 240) ? n : 240) + 16));
            cmp_frame("random_frame_a", cap_a, build_frame(pl, 240));
            cmp_frame("random_frame_b", cap_b, build_frame(pl, 0));
        end

        // trigger held high for three frames, then a stray mid-frame pulse
        pl = make_pl(4, 300);
        wait_idle("held");
        gaps_a.delete();
        gaps_b.delete();
        @(negedge clk);
        trig = 1'b1;
        drive(pl, 1'b0, pl.size());
        drive(pl, 1'b0, pl.size());
        drive(pl, 1'b1, pl.size());
        trig = 1'b1;
        @(posedge clk); #1;
        trig = 1'b0;
        wait_idle("held");
        repeat (100) @(negedge clk);
        chk("held_frames_a", 32'(gaps_a.size()), 32'd3);
        chk("held_frames_b", 32'(gaps_b.size()), 32'd3);
        if (gaps_a.size() >= 3) begin
            chk("held_gap1", 32'(gaps_a[1]), 32'd49);
            chk("held_gap2", 32'(gaps_a[2]), 32'd49);
        end

        // reset in DATA at payload dibit 50, then a clean frame
        pl = make_pl(4, 120);
        wait_idle("midrst");
        @(negedge clk);
        trig = 1'b1;
        @(posedge clk); #1;
        trig = 1'b0;
        drive(pl, 1'b0, 50);
        chk("midrst_pre_axiov", 32'(v_a), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("midrst_axiov", 32'(v_a), 32'd0);
        chk("midrst_axiov_b", 32'(v_b), 32'd0);
        chk("midrst_axiod", 32'(d_a), 32'd0);
        chk("midrst_ready", 32'(rdy_a), 32'd0);
        chk("midrst_data_ready", 32'(drdy_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("midrst_ready_held", 32'(rdy_a), 32'd0);
        @(posedge clk); #1;
        chk("midrst_ready_release", 32'(rdy_a), 32'd1);
        pl = make_pl(0, 36);
        send("after_rst", pl);
        chk("after_rst_fcs", fcs_of(cap_b), 32'hCBF43926);
        cmp_frame("after_rst_frame_a", cap_a, build_frame(pl, 240));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
